accumulator: RTL and testbench
==============================

Name: accumulator

Overview:
- Shift-and-add bit-serial accumulator for the DCIM macro datapath: each enabled cycle, doubles the running sum and adds a new partial sum.
- Combines per-bit-plane partial products (MSB plane first) into a full-precision result.
- Sits after the adder tree; the result feeds the macro output stage.

Parameters:
- A_WIDTH, 27, width of the unsigned partial-sum input `a`.
- OUT_WIDTH, 51, width of the accumulator register / output `nout`; must be >= A_WIDTH.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high; clears accumulator.
- a  input  A_WIDTH  unsigned partial sum to add this cycle.
- acm_en  input  1  accumulate enable.
- st  input  1  start/clear; high clears the accumulator to begin a new sequence.
- nout  output  OUT_WIDTH  accumulator value, driven directly from the register.

Behaviour:
- Single register `acc` of OUT_WIDTH bits; `nout` = `acc`, with no combinational path from inputs to `nout`.
- Evaluate on each posedge clk in this priority order:
  1. rst=1 -> acc <= 0.
  2. else st=1 -> acc <= 0. This applies regardless of acm_en, and `a` is ignored.
  3. else acm_en=1 -> acc <= (acc << 1) + zero_extend(a).
  4. else -> acc holds.
- Reset value of `nout`: 0. Before the first rst cycle the value is undefined; the bench must apply rst first.
- Latency: 1 cycle. The input sampled at edge N is reflected in `nout` after edge N.
- Arithmetic:
  - Unsigned throughout; `a` is zero-extended to OUT_WIDTH.
  - The shift drops acc's MSB.
  - The sum wraps modulo 2^OUT_WIDTH; no saturation and no overflow flag.
- A reset or clear mid-sequence discards the partial result immediately.
- After st deasserts, the first enabled cycle yields acc = a, since (0<<1)+a.
- acm_en=0 with st=0 freezes the value indefinitely; `a` is ignored.
- Inputs are synchronous to clk; no CDC handling inside the block.

Test Plan:
- Reset/idle: hold rst=1 for 1 cycle, then rst=0, st=0, acm_en=0, a=100 for 2 cycles -> nout=0 throughout.
- Basic accumulate: acm_en=1, st=0, a sequence 10,20,30,0 on consecutive edges -> nout 10, 40, 110, 220.
- Clear priority:
  - From nout=220, st=1 with a=999 -> nout=0 after 1 edge.
  - Then st=0, a=5 -> nout=5.
  - Also apply st=1 with acm_en=0 -> nout=0.
- Long sequence: after clear, a=1..10 on successive edges -> nout 1, 4, 11, 26, 57, 120, 247, 502, 1013, 2036.
- Large values: after clear, a=0x7FFFFFF for 6 edges -> nout 0x7FFFFFF, 0x17FFFFFD, 0x37FFFFF9, 0x77FFFFF1, 0xF7FFFFE1, 0x1F7FFFFC1.
- Wrap and reset-mid-operation:
  - Continue a=0x7FFFFFF for 30 total edges -> nout = ((2^30-1)*(2^27-1)) mod 2^51, checked against a reference model.
  - Then assert rst mid-sequence -> nout=0 on the next edge, and accumulation restarts from 0.

Source files
------------

// File: rtl/accumulator.sv
// Shift-and-add bit-serial accumulator. Each enabled cycle the running sum is doubled and a new
// partial sum is added, which merges per-bit-plane partial products (MSB plane first) into a
// full-precision result. The output is driven straight from the register.
module accumulator #(
   parameter int unsigned A_WIDTH   = 27,
   parameter int unsigned OUT_WIDTH = 51  // must be >= A_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [A_WIDTH-1:0]   a,
   input  logic                 acm_en,
   input  logic                 st,
   output logic [OUT_WIDTH-1:0] nout
);

   logic [OUT_WIDTH-1:0] acc_q;
   logic [OUT_WIDTH-1:0] acc_d;
   logic [OUT_WIDTH-1:0] a_ext;

   // Next state: clear on start, shift-and-add when enabled, otherwise hold.
   always_comb begin
      a_ext              = '0;
      a_ext[A_WIDTH-1:0] = a;
      acc_d              = acc_q;
      if (st) begin
         acc_d = '0;
      end else if (acm_en) begin
         // Shift drops the MSB and the add wraps modulo 2^OUT_WIDTH.
         acc_d = (acc_q << 1) + a_ext;
      end
   end

   // Accumulator register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign nout = acc_q;

endmodule

// File: tb/tb_accumulator.sv
// Directed self-checking bench for the shift-and-add accumulator.
module tb_accumulator;

   localparam int unsigned A_WIDTH   = 27;
   localparam int unsigned OUT_WIDTH = 51;

   logic                 clk;
   logic                 rst;
   logic [A_WIDTH-1:0]   a;
   logic                 acm_en;
   logic                 st;
   logic [OUT_WIDTH-1:0] nout;

   int unsigned n_checks;
   int unsigned n_fails;

   accumulator #(
      .A_WIDTH   (A_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .acm_en (acm_en),
      .st     (st),
      .nout   (nout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] big;
      logic [63:0]  exp_v;
      logic [63:0]  long_exp [10];
      logic [63:0]  large_exp [6];

      long_exp  = '{64'd1, 64'd4, 64'd11, 64'd26, 64'd57, 64'd120, 64'd247, 64'd502,
                    64'd1013, 64'd2036};
      large_exp = '{64'h7FFFFFF, 64'h17FFFFFD, 64'h37FFFFF9, 64'h77FFFFF1, 64'hF7FFFFE1,
                    64'h1F7FFFFC1};
      n_checks = 0;
      n_fails  = 0;

      // Reset, then idle with a nonzero input.
      rst = 1'b1; st = 1'b0; acm_en = 1'b0; a = '0;
      step();
      check_val("reset", 64'(nout), 64'd0);
      rst = 1'b0; a = 27'd100;
      step();
      check_val("idle0", 64'(nout), 64'd0);
      step();
      check_val("idle1", 64'(nout), 64'd0);

      // Basic accumulate.
      acm_en = 1'b1;
      a = 27'd10; step(); check_val("acc10", 64'(nout), 64'd10);
      a = 27'd20; step(); check_val("acc20", 64'(nout), 64'd40);
      a = 27'd30; step(); check_val("acc30", 64'(nout), 64'd110);
      a = 27'd0;  step(); check_val("acc0",  64'(nout), 64'd220);

      // Clear wins over enable; first enabled cycle afterwards loads a.
      st = 1'b1; a = 27'd999; step(); check_val("clr_en", 64'(nout), 64'd0);
      st = 1'b0; a = 27'd5;   step(); check_val("first", 64'(nout), 64'd5);
      acm_en = 1'b0; a = 27'd77;
      step(); check_val("hold0", 64'(nout), 64'd5);
      step(); check_val("hold1", 64'(nout), 64'd5);
      st = 1'b1; step(); check_val("clr_noen", 64'(nout), 64'd0);

      // Long sequence a = 1..10.
      st = 1'b0; acm_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a = 27'(i + 1);
         step();
         check_val($sformatf("long%0d", i + 1), 64'(nout), long_exp[i]);
      end

      // Large values: after k edges of all-ones, nout = (2^k-1)*(2^27-1) mod 2^51.
      st = 1'b1; step(); check_val("clr_large", 64'(nout), 64'd0);
      st = 1'b0; a = 27'h7FFFFFF;
      for (int k = 1; k <= 30; k++) begin
         step();
         big   = ((128'd1 << k) - 128'd1) * ((128'd1 << 27) - 128'd1);
         exp_v = 64'(big[OUT_WIDTH-1:0]);
         if (k <= 6) begin
            check_val($sformatf("large%0d", k), 64'(nout), large_exp[k-1]);
         end else begin
            check_val($sformatf("wrap%0d", k), 64'(nout), exp_v);
         end
      end
      check_val("wrap_final", 64'(nout), 64'h7_FFFF_B800_0001);

      // Reset mid-sequence discards the result; accumulation restarts from zero.
      rst = 1'b1; step(); check_val("rst_mid", 64'(nout), 64'd0);
      rst = 1'b0; a = 27'd3; step(); check_val("restart0", 64'(nout), 64'd3);
      a = 27'd4; step(); check_val("restart1", 64'(nout), 64'd10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
